// File: rtl/seqgen_pkg.sv
// -----------------------------------------------------------------------------
// seqgen_pkg
// Shared definitions for the serial pattern transmitter (sequence_generator).
//   - state_t and the FSM state encodings (IDLE, SHIFT, GAP, DONE)
//   - SEQGEN_DEF_PAT : default 4-bit pattern for self-test use
//   - seqgen_busy_cycles() : busy length of one transfer, used by callers that
//     schedule back-to-back transfers
// Optional feature macro: SEQGEN_GAP_EN (inter-repetition gap cycle).
// -----------------------------------------------------------------------------
package seqgen_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'b00;
   localparam state_t SHIFT = 2'b01;
   localparam state_t GAP   = 2'b10;
   localparam state_t DONE  = 2'b11;

   localparam logic [3:0] SEQGEN_DEF_PAT = 4'b1011;

   // Number of busy cycles for one transfer of pat_w bits repeated rep+1 times.
   function automatic int seqgen_busy_cycles(input int pat_w, input int rep, input bit gap_en);
      int n;
      n = (rep + 1) * pat_w;
      if (gap_en) begin
         n = n + rep;
      end else begin
         n = n + 0;
      end
      return n;
   endfunction

endpackage : seqgen_pkg

// File: rtl/seqgen_shifter.sv
// -----------------------------------------------------------------------------
// seqgen_shifter
// PAT_W-bit loadable left-shift register with a held copy of the last captured
// pattern, so each repetition can be reloaded without the caller re-supplying
// the pattern.
// Ports:
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset (clears data and copy)
//   load     in   capture pattern into both the shift register and the copy
//   reload   in   restore the shift register from the held copy
//   shift    in   shift left by one, zero fill
//   pattern  in   PAT_W bits to capture on load
//   msb      out  current MSB of the shift register
// Priority: load > reload > shift > hold.
// -----------------------------------------------------------------------------
module seqgen_shifter #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic             reload,
   input  logic             shift,
   input  logic [PAT_W-1:0] pattern,
   output logic             msb
);

   logic [PAT_W-1:0] data_r;
   logic [PAT_W-1:0] copy_r;

   // Shift register and pattern copy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_r <= {PAT_W{1'b0}};
         copy_r <= {PAT_W{1'b0}};
      end else if (load) begin
         data_r <= pattern;
         copy_r <= pattern;
      end else if (reload) begin
         data_r <= copy_r;
         copy_r <= copy_r;
      end else if (shift) begin
         data_r <= {data_r[PAT_W-2:0], 1'b0};
         copy_r <= copy_r;
      end else begin
         data_r <= data_r;
         copy_r <= copy_r;
      end
   end

   assign msb = data_r[PAT_W-1];

endmodule : seqgen_shifter

// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
// Serial pattern transmitter. On a start strobe in IDLE it captures pattern and
// repeat_n, then sends the pattern MSB-first, one bit per clock, repeat_n+1
// times. busy covers the whole transfer, done pulses for one cycle afterwards.
// Ports:
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset
//   start     in   request strobe, only looked at in IDLE
//   pattern   in   PAT_W bits to send, captured with start
//   repeat_n  in   extra repetitions (0 = send once), captured with start
//   seqout    out  serial data, forced to 0 when valid=0
//   valid     out  seqout carries a pattern bit this cycle
//   busy      out  transfer in progress
//   done      out  one-cycle completion pulse
// Optional feature macro: SEQGEN_GAP_EN -- when defined, one idle cycle
// (valid=0, busy=1) is inserted between repetitions via the GAP state.
// Outputs decode from the state register and shift-register MSB only, so there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module sequence_generator
   import seqgen_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             seqout,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int               BIT_W    = $clog2(PAT_W);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);
   localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
   localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] REP_ZERO = {CNT_W{1'b0}};

   state_t           state_r;
   state_t           state_s;
   logic [BIT_W-1:0] bit_cnt_r;
   logic [CNT_W-1:0] rep_cnt_r;

   logic load_s;
   logic reload_s;
   logic shift_s;
   logic msb_s;

   seqgen_shifter #(
      .PAT_W (PAT_W)
   ) u_shifter (
      .clk     (clk),
      .rstn    (rstn),
      .load    (load_s),
      .reload  (reload_s),
      .shift   (shift_s),
      .pattern (pattern),
      .msb     (msb_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic and datapath control strobes.
   always_comb begin
      state_s  = state_r;
      load_s   = 1'b0;
      reload_s = 1'b0;
      shift_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = SHIFT;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (bit_cnt_r == BIT_ZERO) begin
               // Last bit of a repetition: either finish or rearm from the copy.
               // The final exit leaves the counters at zero rather than wrapping.
               if (rep_cnt_r == REP_ZERO) begin
                  state_s = DONE;
               end else begin
                  reload_s = 1'b1;
`ifdef SEQGEN_GAP_EN
                  state_s  = GAP;
`else
                  state_s  = SHIFT;
`endif
               end
            end else begin
               shift_s = 1'b1;
               state_s = SHIFT;
            end
         end
`ifdef SEQGEN_GAP_EN
         GAP: begin
            state_s = SHIFT;
         end
`endif
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Bit and repeat counters; each reloads or exits at zero, never wraps.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bit_cnt_r <= BIT_ZERO;
         rep_cnt_r <= REP_ZERO;
      end else if (load_s) begin
         bit_cnt_r <= BIT_LAST;
         rep_cnt_r <= repeat_n;
      end else if (reload_s) begin
         bit_cnt_r <= BIT_LAST;
         rep_cnt_r <= rep_cnt_r - REP_ONE;
      end else if (shift_s) begin
         bit_cnt_r <= bit_cnt_r - BIT_ONE;
         rep_cnt_r <= rep_cnt_r;
      end else begin
         bit_cnt_r <= bit_cnt_r;
         rep_cnt_r <= rep_cnt_r;
      end
   end

   // Output decode from the state register; unknown encodings drive all zeros.
   always_comb begin
      seqout = 1'b0;
      valid  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (state_r)
         IDLE: begin
            seqout = 1'b0;
         end
         SHIFT: begin
            seqout = msb_s;
            valid  = 1'b1;
            busy   = 1'b1;
         end
`ifdef SEQGEN_GAP_EN
         GAP: begin
            busy = 1'b1;
         end
`endif
         DONE: begin
            done = 1'b1;
         end
         default: begin
            seqout = 1'b0;
         end
      endcase
   end

endmodule : sequence_generator
